cla_seq_adder_ctrl: RTL and testbench



---
 rtl/cla_seq_adder_ctrl_pkg.sv | 13 +
 rtl/cla_seq_adder_ctrl_clg4.sv | 30 +++
 rtl/cla_seq_adder_ctrl_slice4.sv | 33 +++
 rtl/cla_seq_adder_ctrl.sv | 134 +++++++++++++
 tb/tb_cla_seq_adder_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cla_seq_adder_ctrl_pkg.sv
// rtl/cla_seq_adder_ctrl_pkg.sv - shared types and constants for the nibble-serial CLA adder
// Purpose: state encoding and slice width used by the controller and the CLA slice.
package cla_seq_adder_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_seq_adder_ctrl_clg4.sv
// rtl/cla_seq_adder_ctrl_clg4.sv - 4-bit carry-lookahead generator
// Purpose: full two-level lookahead expansion of carries C1..C4 from P/G and carry-in.
// Ports:
//   p_i[3:0]  propagate terms
//   g_i[3:0]  generate terms
//   c_i       carry into bit 0
//   c_o[4:1]  carries into bits 1..3 and out of bit 3
module cla_gen4 (
    input  logic [3:0] p_i,
    input  logic [3:0] g_i,
    input  logic       c_i,
    output logic [4:1] c_o
);

    assign c_o[1] = g_i[0]
                  | (p_i[0] & c_i);
    assign c_o[2] = g_i[1]
                  | (p_i[1] & g_i[0])
                  | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2]
                  | (p_i[2] & g_i[1])
                  | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c_i);
    assign c_o[4] = g_i[3]
                  | (p_i[3] & g_i[2])
                  | (p_i[3] & p_i[2] & g_i[1])
                  | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
                  | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c_i);

endmodule

// File: rtl/cla_seq_adder_ctrl_slice4.sv
// rtl/cla_seq_adder_ctrl_slice4.sv - combinational 4-bit CLA adder slice
// Purpose: one nibble of addition; builds P/G and feeds the lookahead generator.
// Ports:
//   a_i[3:0], b_i[3:0]  operand nibbles
//   c_i                 carry into the nibble
//   sum_o[3:0]          sum nibble
//   c_o[4:1]            internal carries; c_o[4] is the nibble carry-out
module cla_slice4
    import cla_seq_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic [4:1]         c_o
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    cla_gen4 u_clg (
        .p_i (p),
        .g_i (g),
        .c_i (c_i),
        .c_o (c_o)
    );

    assign sum_o = p ^ {c_o[3:1], c_i};

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// rtl/cla_seq_adder_ctrl.sv - nibble-serial wide adder sharing one 4-bit CLA slice
// Purpose: adds WIDTH-bit A + B + Cin one nibble per clock, LSB first, with
//          valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid/in_ready, A, B, Cin operand side
//   out_valid/out_ready          result side
//   S, Cout, Ovf                 sum, carry-out, signed overflow (held in DONE)
//   busy                         high while nibbles are being computed
module cla_seq_adder_ctrl
    import cla_seq_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int STEP_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("cla_seq_adder_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t             state_q;
    logic [STEP_W-1:0]  step_q;
    logic [STEP_W-1:0]  step_d;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   s_q;
    logic               cout_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;

    logic [SLICE_W-1:0] slice_sum;
    logic [4:1]         slice_c;
    logic               unused_slice_c;

    cla_slice4 u_slice (
        .a_i   (a_q[SLICE_W*int'(step_q) +: SLICE_W]),
        .b_i   (b_q[SLICE_W*int'(step_q) +: SLICE_W]),
        .c_i   (carry_q),
        .sum_o (slice_sum),
        .c_o   (slice_c)
    );

    // Only the top two carries matter outside the slice (carry-out and MSB carry-in).
    assign unused_slice_c = ^slice_c[2:1];

    assign step_d = step_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        carry_q    <= Cin;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    s_q[SLICE_W*int'(step_q) +: SLICE_W] <= slice_sum;
                    carry_q <= slice_c[4];
                    if (step_q == LAST_STEP) begin
                        // Step stays at the last index so it never wraps.
                        cout_q      <= slice_c[4];
                        ovf_q       <= slice_c[3] ^ slice_c[4];
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        step_q <= step_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb/tb_cla_seq_adder_ctrl.sv - self-checking bench for the nibble-serial CLA adder
module tb_cla_seq_adder_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         Ovf;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition; overflow from operand/result sign bits.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] sum;
        logic       ovf;
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        return {ovf, sum};
    endfunction

    // Full transaction: accept, check exact latency and result, hold, then drain.
    task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] es, input logic ec,
                           input logic eo, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 12) begin tick(); n++; end
        check({tag, "_latency"}, 32'(n), 32'd4);
        repeat (hold) tick();
        check({tag, "_S"}, 32'(S), 32'(es));
        check({tag, "_Cout"}, 32'(Cout), 32'(ec));
        check({tag, "_Ovf"}, 32'(Ovf), 32'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra, rb, held;
        logic         rc;
        int n;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF; Cin = 1'b1;

        // Reset and idle behaviour
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_S", 32'(S), 32'd0);
        check("rst_Cout", 32'(Cout), 32'd0);
        check("rst_Ovf", 32'(Ovf), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Directed table
        for (int i = 0; i < 6; i++)
            run_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].s, vecs[i].cout, vecs[i].ovf, 0);

        // Randomized against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;
            m = model(ra, rb, rc);
            run_add($sformatf("rnd%0d", i), ra, rb, rc, m[W-1:0], m[W], m[W+1],
                    int'($urandom_range(0, 3)));
        end

        // Backpressure with in_valid held high and operands changing
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; in_valid = 1'b1;
        tick();
        n = 0;
        while (!out_valid && n < 12) begin
            A = W'($urandom); B = W'($urandom);
            tick(); n++;
        end
        check("bp_latency", 32'(n), 32'd4);
        held = 16'h3333;
        for (int i = 0; i < 5; i++) begin
            A = W'($urandom); B = W'($urandom);
            tick();
            check($sformatf("bp_S_%0d", i), 32'(S), 32'(held));
            check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
        end
        A = 16'h0005; B = 16'h0003; Cin = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_out_valid", 32'(out_valid), 32'd0);
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_accept", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 12) begin tick(); n++; end
        check("bp_next_latency", 32'(n), 32'd4);
        check("bp_next_S", 32'(S), 32'h0008);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a run
        A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_S", 32'(S), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) tick();
        check("mid_rst_no_result", 32'(out_valid), 32'd0);
        run_add("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
